// File: rtl/dffram_pkg.sv
// dffram_pkg -- shared types and helpers for the dffram_bw_sync RAM.
//   state_e  : clear-sequencer FSM states
//   BYTE_W   : width of one write-enable lane
//   byte_par : even parity of one byte (XOR reduce)
package dffram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    localparam int BYTE_W = 8;

    function automatic logic byte_par(input logic [BYTE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/dffram_bw_sync_if.sv
// dffram_bw_sync_if -- request/response bundle between a requester (core
// memory interface or APB bridge) and the dffram_bw_sync RAM.
//   EN, WE[NB], A, Di       : request (requester -> RAM)
//   Do, DoValid, BUSY, ERR,
//   PERR                    : response/status (RAM -> requester)
// Modports: master = requester side, slave = RAM side.
interface dffram_bw_sync_if
    import dffram_pkg::*;
#(
    parameter int DATA_LENGTH    = 32,
    parameter int ADDRESS_LENGTH = 32
);
    localparam int NB = DATA_LENGTH / BYTE_W;

    logic                      EN;
    logic [NB-1:0]             WE;
    logic [ADDRESS_LENGTH-1:0] A;
    logic [DATA_LENGTH-1:0]    Di;
    logic [DATA_LENGTH-1:0]    Do;
    logic                      DoValid;
    logic                      BUSY;
    logic                      ERR;
    logic                      PERR;

    modport master (
        output EN, WE, A, Di,
        input  Do, DoValid, BUSY, ERR, PERR
    );

    modport slave (
        input  EN, WE, A, Di,
        output Do, DoValid, BUSY, ERR, PERR
    );
endinterface

// File: rtl/dffram_clear_seq.sv
// dffram_clear_seq -- post-reset zero sweep over every word of the RAM.
//   CLK, RST     : clock, synchronous active-high reset
//   o_busy       : high while the sweep runs (state == ST_CLEAR)
//   o_clr_we     : clear write strobe for the current sweep word
//   o_clr_addr   : word being cleared this cycle
// The sweep writes one word per cycle from 0 to DEPTH-1 and drops BUSY on
// the edge that writes the last word, so it lasts exactly DEPTH cycles.
module dffram_clear_seq
    import dffram_pkg::*;
#(
    parameter int DEPTH = 2048
) (
    input  logic                       CLK,
    input  logic                       RST,
    output logic                       o_busy,
    output logic                       o_clr_we,
    output logic [$clog2(DEPTH)-1:0]   o_clr_addr
);
    localparam int CW = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    state_e        r_state,    w_state_nxt;
    logic [CW-1:0] r_clr_addr, w_clr_addr_nxt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        o_clr_we       = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                o_clr_we       = !RST;
                w_clr_addr_nxt = r_clr_addr + 1'b1;
                if (r_clr_addr == LAST)
                    w_state_nxt = ST_IDLE;
            end
            default: ;
        endcase
    end

    // BUSY is a pure decode of the state register, so it rises on the reset
    // edge and falls on the edge that writes the last word.
    assign o_busy     = (r_state == ST_CLEAR);
    assign o_clr_addr = r_clr_addr;
endmodule

// File: rtl/dffram_bw_sync.sv
// dffram_bw_sync -- single-port synchronous RAM, per-byte write enables,
// registered read data with a read-valid strobe, post-reset clear sweep,
// out-of-range detection.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : dffram_bw_sync_if.slave (EN/WE/A/Di in; Do/DoValid/BUSY/ERR/PERR out)
// Optional feature macro: DFFRAM_PARITY_EN -- adds one even-parity bit per
// byte lane and the PERR check on reads; otherwise PERR is tied low.
module dffram_bw_sync
    import dffram_pkg::*;
#(
    parameter int DATA_LENGTH    = 32,
    parameter int DEPTH          = 2048,
    parameter int ADDRESS_LENGTH = 32
) (
    input  logic              CLK,
    input  logic              RST,
    dffram_bw_sync_if.slave   bus
);
    localparam int NB = DATA_LENGTH / BYTE_W;
    localparam int CW = $clog2(DEPTH);
    // One extra bit so the compare covers every address bit, even when DEPTH
    // does not fit in ADDRESS_LENGTH bits.
    localparam logic [ADDRESS_LENGTH:0] DEPTH_W = (ADDRESS_LENGTH + 1)'(DEPTH);

    logic          w_busy;
    logic          w_clr_we;
    logic [CW-1:0] w_clr_addr;

    dffram_clear_seq #(.DEPTH(DEPTH)) u_clr (
        .CLK        (CLK),
        .RST        (RST),
        .o_busy     (w_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    logic          w_req, w_rd, w_wr, w_in_range, w_par_err;
    logic [CW-1:0] w_idx;

    // Requests are dropped during the sweep and on any reset edge.
    assign w_req      = bus.EN && !w_busy && !RST;
    assign w_rd       = w_req && (bus.WE == '0);
    assign w_wr       = w_req && (bus.WE != '0);
    assign w_in_range = ({1'b0, bus.A} < DEPTH_W);
    assign w_idx      = bus.A[CW-1:0];

    logic [DATA_LENGTH-1:0] r_mem [DEPTH];

    // Clear writes and user writes never coincide (user requests are gated
    // by BUSY), so the priority here is only for readability.
    always_ff @(posedge CLK) begin
        if (w_clr_we)
            r_mem[w_clr_addr] <= '0;
        else if (w_wr && w_in_range)
            for (int i = 0; i < NB; i++)
                if (bus.WE[i])
                    r_mem[w_idx][i*BYTE_W +: BYTE_W] <= bus.Di[i*BYTE_W +: BYTE_W];
    end

`ifdef DFFRAM_PARITY_EN
    logic [NB-1:0] r_par [DEPTH];

    always_ff @(posedge CLK) begin
        if (w_clr_we)
            r_par[w_clr_addr] <= '0;
        else if (w_wr && w_in_range)
            for (int i = 0; i < NB; i++)
                if (bus.WE[i])
                    r_par[w_idx][i] <= byte_par(bus.Di[i*BYTE_W +: BYTE_W]);
    end

    always_comb begin
        w_par_err = 1'b0;
        for (int i = 0; i < NB; i++)
            if (byte_par(r_mem[w_idx][i*BYTE_W +: BYTE_W]) != r_par[w_idx][i])
                w_par_err = 1'b1;
    end
`else
    assign w_par_err = 1'b0;
`endif

    logic [DATA_LENGTH-1:0] r_do;
    logic                   r_dovalid, r_err, r_perr;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_do      <= '0;
            r_dovalid <= 1'b0;
            r_err     <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            r_dovalid <= w_rd;
            r_err     <= w_req && !w_in_range;
            r_perr    <= w_rd && w_in_range && w_par_err;
            // Out-of-range reads return zero rather than an aliased word.
            if (w_rd)
                r_do <= w_in_range ? r_mem[w_idx] : '0;
        end
    end

    assign bus.Do      = r_do;
    assign bus.DoValid = r_dovalid;
    assign bus.BUSY    = w_busy;
    assign bus.ERR     = r_err;
`ifdef DFFRAM_PARITY_EN
    assign bus.PERR    = r_perr;
`else
    assign bus.PERR    = 1'b0;
`endif
endmodule
